// File: rtl/dmem_stage_ctrl_pkg.sv
// Shared definitions for the memory-stage access controller: FSM state
// encoding, the full-word byte-enable constant and small lane helpers.
package dmem_stage_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] BE_WORD = 4'hF;

    function automatic logic [3:0] byte_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    function automatic logic [31:0] byte_replicate(input logic [7:0] b);
        return {4{b}};
    endfunction

endpackage

// File: rtl/dmem_stage_ctrl_if.sv
// Request/ack data-memory port. The controller is the master; the memory
// model or real memory is the slave.
interface dmem_stage_ctrl_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_stage_ctrl_lane.sv
// Combinational byte-lane steering for the memory stage: builds the store
// byte enables and replicated store data, and extracts a zero-extended
// byte from the returned read word for byte loads.
module dmem_lane
    import dmem_stage_ctrl_pkg::*;
(
    input  logic        byte_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    // Store side: a byte store drives one lane and copies the byte to all lanes
    always_comb begin
        be_o    = BE_WORD;
        wdata_o = wdata_i;
        if (byte_i) begin
            be_o    = byte_be(lane_i);
            wdata_o = byte_replicate(wdata_i[7:0]);
        end
    end

    // Load side: a byte load picks the addressed lane and zero-extends it
    always_comb begin
        rdata_o = rdata_i;
        if (byte_i) begin
            case (lane_i)
                2'd0:    rdata_o = {24'h0, rdata_i[7:0]};
                2'd1:    rdata_o = {24'h0, rdata_i[15:8]};
                2'd2:    rdata_o = {24'h0, rdata_i[23:16]};
                default: rdata_o = {24'h0, rdata_i[31:24]};
            endcase
        end
    end

endmodule

// File: rtl/dmem_stage_ctrl.sv
// Memory-stage access controller. Turns each load/store in the M stage into
// one request/ack transaction on a variable-latency memory port, stalling
// the pipeline until the access finishes, times out, or is rejected as
// misaligned.
module dmem_stage_ctrl
    import dmem_stage_ctrl_pkg::*;
#(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               MemReadM,
    input  logic               MemWriteM,
    input  logic               ByteM,
    input  logic [31:0]        ALUOutM,
    input  logic [31:0]        WriteDataM,
    output logic [31:0]        ReadDataM,
    output logic               MemStallM,
    output logic               BusErrM,
    output logic               MisalignM,
    dmem_stage_ctrl_if.master  mem
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        read_data_q, read_data_d;
    logic               bus_err_q, bus_err_d;
    logic               misalign_q, misalign_d;

    logic               acc;
    logic               misaligned;
    logic               timeout_hit;
    logic [3:0]         lane_be;
    logic [31:0]        lane_wdata;
    logic [31:0]        lane_rdata;

    assign acc         = MemReadM | MemWriteM;
    assign misaligned  = !ByteM && (ALUOutM[1:0] != 2'b00);
    assign timeout_hit = (count_q == CNT_LAST);

    dmem_lane u_lane (
        .byte_i  (ByteM),
        .lane_i  (ALUOutM[1:0]),
        .wdata_i (WriteDataM),
        .rdata_i (mem.mem_rdata),
        .be_o    (lane_be),
        .wdata_o (lane_wdata),
        .rdata_o (lane_rdata)
    );

    // Next-state and timeout counter: ack always beats the timeout
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    if (misaligned) begin
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                        count_d = '0;
                    end
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    state_d = DONE;
                end else if (timeout_hit) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output next values: launch the bus request, capture the load result, raise the DONE pulses
    always_comb begin
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        read_data_d = read_data_q;
        bus_err_d   = 1'b0;
        misalign_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    if (misaligned) begin
                        misalign_d  = 1'b1;
                        read_data_d = ERR_DATA;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = MemWriteM;
                        addr_d  = {ALUOutM[31:2], 2'b00};
                        wdata_d = lane_wdata;
                        be_d    = lane_be;
                    end
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        read_data_d = lane_rdata;
                    end
                end else if (timeout_hit) begin
                    req_d       = 1'b0;
                    bus_err_d   = 1'b1;
                    read_data_d = ERR_DATA;
                end
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
    end

    // State, counter and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            read_data_q <= '0;
            bus_err_q   <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            read_data_q <= read_data_d;
            bus_err_q   <= bus_err_d;
            misalign_q  <= misalign_d;
        end
    end

    assign MemStallM     = acc && (state_q != DONE);
    assign ReadDataM     = read_data_q;
    assign BusErrM       = bus_err_q;
    assign MisalignM     = misalign_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_be    = be_q;

endmodule

// File: tb/tb_dmem_stage_ctrl.sv
// Testbench for dmem_stage_ctrl: directed scenarios plus randomized accesses,
// each checked against a transaction-level model of latency, lanes and errors.
module tb_dmem_stage_ctrl;

    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] ERR_DATA = 32'h0;
    localparam int          NO_ACK   = TIMEOUT + 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM, ByteM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        MemStallM, BusErrM, MisalignM;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_rd;

    always #5 clk = ~clk;

    dmem_stage_ctrl_if mem_if ();

    dmem_stage_ctrl #(
        .TIMEOUT  (TIMEOUT),
        .ERR_DATA (ERR_DATA)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ByteM      (ByteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .MemStallM  (MemStallM),
        .BusErrM    (BusErrM),
        .MisalignM  (MisalignM),
        .mem        (mem_if)
    );

    // One complete access: the memory acks after ack_k extra request cycles
    // (ack_k >= TIMEOUT means it never acks). Ends at the cycle after DONE
    // with the access inputs still applied, so the caller can chain accesses.
    task automatic do_access(input bit is_load, input bit is_byte,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int ack_k, input logic [31:0] rdata,
                             input string tag);
        int          lane;
        bit          exp_mis, exp_err, done;
        int          exp_req, exp_stall;
        logic [31:0] exp_rd, exp_addr, exp_wd;
        logic [3:0]  exp_be;
        int          stall_cnt, req_cnt, field_bad;
        logic [31:0] got_rd;
        logic        got_err, got_mis;

        lane      = int'(addr[1:0]);
        exp_mis   = !is_byte && (lane != 0);
        exp_addr  = addr - 32'(lane);
        exp_be    = is_byte ? 4'(1 << lane) : 4'hF;
        exp_wd    = is_byte ? (wd & 32'hFF) * 32'h0101_0101 : wd;
        exp_err   = 1'b0;
        if (exp_mis) begin
            exp_req   = 0;
            exp_stall = 1;
            exp_rd    = ERR_DATA;
        end else if (ack_k < TIMEOUT) begin
            exp_req   = ack_k + 1;
            exp_stall = ack_k + 2;
            if (is_load)
                exp_rd = is_byte ? ((rdata >> (8 * lane)) & 32'hFF) : rdata;
            else
                exp_rd = model_rd;
        end else begin
            exp_req   = TIMEOUT;
            exp_stall = TIMEOUT + 1;
            exp_err   = 1'b1;
            exp_rd    = ERR_DATA;
        end

        MemReadM   = is_load;
        MemWriteM  = !is_load;
        ByteM      = is_byte;
        ALUOutM    = addr;
        WriteDataM = wd;
        stall_cnt  = 0;
        req_cnt    = 0;
        field_bad  = 0;
        done       = 1'b0;
        got_rd     = '0;
        got_err    = 1'b0;
        got_mis    = 1'b0;

        for (int cyc = 0; cyc < TIMEOUT + 8 && !done; cyc++) begin
            mem_if.mem_ack   = mem_if.mem_req && (req_cnt == ack_k);
            mem_if.mem_rdata = mem_if.mem_ack ? rdata : $urandom;
            @(negedge clk);
            if (mem_if.mem_req === 1'b1) begin
                req_cnt++;
                if (mem_if.mem_we !== !is_load || mem_if.mem_addr !== exp_addr ||
                    mem_if.mem_wdata !== exp_wd || mem_if.mem_be !== exp_be)
                    field_bad++;
            end
            if (MemStallM === 1'b1) begin
                stall_cnt++;
            end else begin
                done    = 1'b1;
                got_rd  = ReadDataM;
                got_err = BusErrM;
                got_mis = MisalignM;
            end
            @(posedge clk);
            #1;
        end
        mem_if.mem_ack = 1'b0;

        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL %s done_reached got none within %0d cycles expected DONE", tag, TIMEOUT + 8);
        end else begin
            checks++;
            if (stall_cnt !== exp_stall) begin
                errors++;
                $display("[TB] FAIL %s stall_cycles got %0d expected %0d", tag, stall_cnt, exp_stall);
            end
            checks++;
            if (req_cnt !== exp_req) begin
                errors++;
                $display("[TB] FAIL %s req_cycles got %0d expected %0d", tag, req_cnt, exp_req);
            end
            if (exp_req > 0) begin
                checks++;
                if (field_bad != 0) begin
                    errors++;
                    $display("[TB] FAIL %s bus_fields got we=%0b addr=%h wdata=%h be=%b expected we=%0b addr=%h wdata=%h be=%b",
                             tag, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_be,
                             !is_load, exp_addr, exp_wd, exp_be);
                end
            end
            checks++;
            if (got_rd !== exp_rd) begin
                errors++;
                $display("[TB] FAIL %s read_data got %h expected %h", tag, got_rd, exp_rd);
            end
            checks++;
            if (got_err !== exp_err) begin
                errors++;
                $display("[TB] FAIL %s bus_err got %0b expected %0b", tag, got_err, exp_err);
            end
            checks++;
            if (got_mis !== exp_mis) begin
                errors++;
                $display("[TB] FAIL %s misalign got %0b expected %0b", tag, got_mis, exp_mis);
            end
            model_rd = exp_rd;
        end
    endtask

    // A cycle with no access; optionally a stray ack that must be ignored
    task automatic idle_cycle(input bit late_ack, input string tag);
        MemReadM         = 1'b0;
        MemWriteM        = 1'b0;
        mem_if.mem_ack   = late_ack;
        mem_if.mem_rdata = $urandom;
        @(negedge clk);
        checks++;
        if (MemStallM !== 1'b0 || BusErrM !== 1'b0 || MisalignM !== 1'b0 || mem_if.mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s idle_quiet got stall=%b buserr=%b misalign=%b req=%b expected all 0",
                     tag, MemStallM, BusErrM, MisalignM, mem_if.mem_req);
        end
        checks++;
        if (ReadDataM !== model_rd) begin
            errors++;
            $display("[TB] FAIL %s idle_hold got %h expected %h", tag, ReadDataM, model_rd);
        end
        @(posedge clk);
        #1;
        mem_if.mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        MemReadM         = 1'b0;
        MemWriteM        = 1'b0;
        ByteM            = 1'b0;
        ALUOutM          = '0;
        WriteDataM       = '0;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (ReadDataM !== 32'h0 || MemStallM !== 1'b0 || BusErrM !== 1'b0 || MisalignM !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got rd=%h stall=%b buserr=%b misalign=%b expected 0", ReadDataM, MemStallM, BusErrM, MisalignM);
        end
        checks++;
        if (mem_if.mem_req !== 1'b0 || mem_if.mem_we !== 1'b0 || mem_if.mem_addr !== 32'h0 ||
            mem_if.mem_wdata !== 32'h0 || mem_if.mem_be !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_bus got req=%b we=%b addr=%h wdata=%h be=%h expected 0",
                     mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_be);
        end
        model_rd = 32'h0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_word_load();
        do_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 3, 32'hCAFE_F00D, "word_load");
        idle_cycle(1'b0, "word_load");
    endtask

    task automatic test_byte_store();
        do_access(1'b0, 1'b1, 32'h0000_0203, 32'h1234_5678, 0, 32'hDEAD_BEEF, "byte_store");
        idle_cycle(1'b0, "byte_store");
    endtask

    task automatic test_byte_load();
        do_access(1'b1, 1'b1, 32'h0000_0002, 32'h0, 1, 32'hAABB_CCDD, "byte_load");
        idle_cycle(1'b0, "byte_load");
    endtask

    task automatic test_misalign();
        do_access(1'b1, 1'b0, 32'h0000_0101, 32'h0, 0, 32'h1111_1111, "misalign_load");
        idle_cycle(1'b0, "misalign_load");
        do_access(1'b0, 1'b0, 32'h0000_0302, 32'h5555_AAAA, 0, 32'h0, "misalign_store");
        idle_cycle(1'b0, "misalign_store");
    endtask

    task automatic test_timeout();
        do_access(1'b1, 1'b0, 32'h0000_0400, 32'h0, NO_ACK, 32'h0, "timeout");
        idle_cycle(1'b1, "late_ack");
        idle_cycle(1'b0, "after_late_ack");
        do_access(1'b1, 1'b0, 32'h0000_0404, 32'h0, TIMEOUT - 1, 32'h0BAD_CAFE, "ack_at_timeout");
        idle_cycle(1'b0, "ack_at_timeout");
    endtask

    task automatic test_reset_mid_req();
        MemReadM       = 1'b1;
        MemWriteM      = 1'b0;
        ByteM          = 1'b0;
        ALUOutM        = 32'h0000_0800;
        WriteDataM     = 32'h0;
        mem_if.mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b1;
        MemReadM = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        model_rd = 32'h0;
        checks++;
        if (mem_if.mem_req !== 1'b0 || MemStallM !== 1'b0 || ReadDataM !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid_req got req=%b stall=%b rd=%h expected 0 0 0", mem_if.mem_req, MemStallM, ReadDataM);
        end
        @(posedge clk);
        #1;
        do_access(1'b1, 1'b0, 32'h0000_0804, 32'h0, 2, 32'h600D_0001, "after_reset");
        idle_cycle(1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        do_access(1'b0, 1'b0, 32'h0000_0900, 32'hFEED_BEEF, 1, 32'h0, "b2b_store");
        do_access(1'b1, 1'b0, 32'h0000_0900, 32'h0, 0, 32'h1357_9BDF, "b2b_load");
        idle_cycle(1'b0, "b2b");
    endtask

    task automatic test_random();
        bit          is_load, is_byte;
        logic [31:0] addr, wd, rd;
        int          r, ack_k;
        for (int n = 0; n < 40; n++) begin
            is_load = $urandom_range(0, 1) == 1;
            is_byte = $urandom_range(0, 1) == 1;
            addr    = $urandom;
            wd      = $urandom;
            rd      = $urandom;
            if (!is_byte && $urandom_range(0, 3) != 0)
                addr = addr & 32'hFFFF_FFFC;
            r = $urandom_range(0, 9);
            if (r == 9)
                ack_k = NO_ACK;
            else if (r == 8)
                ack_k = TIMEOUT - 1;
            else
                ack_k = r;
            do_access(is_load, is_byte, addr, wd, ack_k, rd, "random");
            if ($urandom_range(0, 1) == 1)
                idle_cycle(1'b0, "random_gap");
        end
        idle_cycle(1'b0, "random_end");
    endtask

    // Scenario sequence followed by the single summary line
    initial begin
        model_rd = 32'h0;
        test_reset();
        test_word_load();
        test_byte_store();
        test_byte_load();
        test_misalign();
        test_timeout();
        test_reset_mid_req();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
